// File: rtl/sweep_sequencer.sv
// Stepped-frequency sweep controller for the ROM sine generator: holds each phase
// increment for a programmable dwell, steps towards a stop value, then finishes or loops.
module sweep_sequencer #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DWELL_WIDTH   = 16,
    parameter int LAT           = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDRESS_WIDTH-1:0] cfg_incr_start,
    input  logic [ADDRESS_WIDTH-1:0] cfg_incr_step,
    input  logic [ADDRESS_WIDTH-1:0] cfg_incr_stop,
    input  logic [DWELL_WIDTH-1:0]   cfg_dwell,
    input  logic                     cfg_loop,
    output logic                     gen_en,
    output logic [ADDRESS_WIDTH-1:0] gen_incr,
    output logic                     busy,
    output logic                     done,
    output logic                     sample_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] cur_incr;
    logic [ADDRESS_WIDTH-1:0] next_incr;
    logic [ADDRESS_WIDTH-1:0] sh_start;
    logic [ADDRESS_WIDTH-1:0] sh_step;
    logic [ADDRESS_WIDTH-1:0] sh_stop;
    logic [DWELL_WIDTH-1:0]   sh_dwell;
    logic                     sh_loop;
    logic [DWELL_WIDTH-1:0]   dwell_cnt;
    logic [DWELL_WIDTH-1:0]   next_cnt;
    logic [DWELL_WIDTH-1:0]   eff_dwell;
    logic                     last_dwell;
    logic                     load;
    logic [ADDRESS_WIDTH:0]   sum;
    logic [ADDRESS_WIDTH-1:0] stepped;
    logic [LAT-1:0]           en_pipe;

    // The extra sum bit catches wrap-around so an overflowing step still lands on stop.
    assign eff_dwell  = (sh_dwell == '0) ? DWELL_WIDTH'(1) : sh_dwell;
    assign last_dwell = (dwell_cnt == eff_dwell - DWELL_WIDTH'(1));
    assign sum        = {1'b0, cur_incr} + {1'b0, sh_step};
    assign stepped    = (sum >= {1'b0, sh_stop}) ? sh_stop : sum[ADDRESS_WIDTH-1:0];

    always_comb begin
        next_state = state;
        next_incr  = cur_incr;
        next_cnt   = dwell_cnt;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load       = 1'b1;
                    next_incr  = cfg_incr_start;
                    next_cnt   = '0;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (last_dwell) begin
                    next_cnt = '0;
                    if (cur_incr >= sh_stop) begin
                        if (sh_loop) begin
                            next_incr = sh_start;
                        end else begin
                            next_state = DONE;
                        end
                    end else begin
                        next_incr = stepped;
                    end
                end else begin
                    next_cnt = dwell_cnt + DWELL_WIDTH'(1);
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_incr  <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= next_state;
            cur_incr  <= next_incr;
            dwell_cnt <= next_cnt;
        end
    end

    // Configuration is captured once per sweep so mid-sweep register writes are harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_start <= '0;
            sh_step  <= '0;
            sh_stop  <= '0;
            sh_dwell <= '0;
            sh_loop  <= 1'b0;
        end else if (load) begin
            sh_start <= cfg_incr_start;
            sh_step  <= cfg_incr_step;
            sh_stop  <= cfg_incr_stop;
            sh_dwell <= cfg_dwell;
            sh_loop  <= cfg_loop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_pipe <= '0;
        end else begin
            en_pipe[0] <= gen_en;
            for (int i = 1; i < LAT; i++) begin
                en_pipe[i] <= en_pipe[i-1];
            end
        end
    end

    assign gen_en       = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign gen_incr     = (state == RUN) ? cur_incr : '0;
    assign sample_valid = en_pipe[LAT-1];

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Controller that drives the enable and phase-increment inputs of the ROM-based sine generator to produce stepped-frequency sweeps (chirps). It latches a sweep configuration on `start`, holds each increment for a programmable dwell, and steps the increment towards a stop value. It then finishes or loops. It sits between the register/control layer and the sine generator, and also provides a `sample_valid` strobe aligned to the generator's output latency.

## Interface
- `ADDRESS_WIDTH`, default 8: width of the phase increment; must match the generator.
- `DWELL_WIDTH`, default 16: width of the dwell counter.
- `LAT`, default 2: generator latency in cycles, from `en` to valid `dout`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a sweep when sampled high in IDLE.
- `stop`  in  1  aborts a running sweep.
- `cfg_incr_start`  in  ADDRESS_WIDTH  first increment.
- `cfg_incr_step`  in  ADDRESS_WIDTH  step added after each dwell.
- `cfg_incr_stop`  in  ADDRESS_WIDTH  final increment.
- `cfg_dwell`  in  DWELL_WIDTH  cycles per increment; 0 is treated as 1.
- `cfg_loop`  in  1  1 means restart from start after the final dwell.
- `gen_en`  out  1  enable to the generator.
- `gen_incr`  out  ADDRESS_WIDTH  increment to the generator.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at normal completion.
- `sample_valid`  out  1  `gen_en` delayed by LAT cycles.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `gen_en`=0 and `busy`=0.
  - `start`=1 and `stop`=0: latch all `cfg_*` inputs into shadow registers, set cur_incr=start, clear dwell_cnt, go to RUN.
  - `start` and `stop` both high: `stop` wins, remain in IDLE.
- RUN:
  - `gen_en`=1, `gen_incr`=cur_incr, `busy`=1. dwell_cnt counts 0..max(dwell,1)-1.
  - At the last dwell cycle, when cur_incr ≥ stop (unsigned):
    - loop=1: cur_incr←start, stay in RUN.
    - loop=0: go to DONE.
  - At the last dwell cycle otherwise: cur_incr←min(cur_incr+step, stop).
    - The sum is computed ADDRESS_WIDTH+1 bits wide, so a wrapping sum clamps to stop.
    - The final increment is always exactly stop.
  - Step 0 with start<stop: hold the start increment indefinitely; only `stop` ends the sweep.
  - Start>stop: one dwell at start, then finish or loop.
  - `stop`=1 in RUN: go to IDLE next cycle, no `done` pulse. `stop` takes priority over a dwell-end transition in the same cycle.
  - `start` while in RUN or DONE: ignored. `cfg_*` changes mid-sweep have no effect.
- DONE: `gen_en`=0, `done`=1 for one cycle, then IDLE unconditionally.
- `sample_valid` is an LAT-deep shift register of `gen_en`.
- Reset (asynchronous, any state):
  - FSM to IDLE, all counters and shadow registers to 0, shift register flushed.
  - Outputs `gen_en`, `gen_incr`, `busy`, `done`, `sample_valid` all 0.
  - Reset mid-sweep drops `gen_en` immediately.

## Timing
- `start` sampled high at edge N: edge N+1 enters RUN; from then `gen_en`=1 and `gen_incr`=start.
- Each increment is presented for exactly max(dwell,1) consecutive cycles. Increment changes are seamless, with no `gen_en` gap between steps or on loop.
- Registered outputs only, no combinational input-to-output paths.
- After the final dwell cycle: one DONE cycle (`done`=1, `gen_en`=0), then IDLE. Earliest restart is the `start` sampled in the first IDLE cycle after DONE.
- `stop` sampled at edge M: `gen_en`=0 from edge M+1.
- `sample_valid` rises LAT cycles after `gen_en` rises and falls LAT cycles after it falls.

## Test plan
- Reset and idle: hold `rst` low then release, no `start` -> all outputs 0 for 20 cycles.
- Basic sweep: start=10, step=5, stop=20, dwell=3, loop=0 -> `gen_incr` 10,10,10,15,15,15,20,20,20; then `done` for 1 cycle; `gen_en` high for exactly 9 cycles.
- Clamp and wrap: start=250, step=10, stop=255, dwell=1 (ADDRESS_WIDTH=8) -> `gen_incr` 250, 255, then `done`; no wrap to 4.
- Loop and abort: start=1, step=1, stop=3, dwell=2, loop=1 -> 1,1,2,2,3,3,1,1,... continuous; `stop` asserted mid-sweep -> `gen_en`=0 next cycle, no `done`.
- Edge configs:
  - dwell=0 -> behaves as dwell=1.
  - step=0, start=5, stop=9 -> 5 held until `stop`.
  - start=9, stop=5 -> one dwell at 9, then `done`.
  - start+stop together in IDLE -> stays IDLE.
- Latency and reset: LAT=2 -> `sample_valid` trails `gen_en` by 2 cycles on both edges. Async `rst` low mid-sweep -> all outputs 0 without waiting for a clock edge.
